turret1_sprite_fetch: RTL and testbench

// - Upstream feeder of the turret palette stage. Per VGA pixel, decides if (DrawX,DrawY) lies in the
//   32x32 turret sprite, rotates sprite coords by turret direction, reads turret index ROM.
// - Emits an 8-bit palette index plus valid flag, at fixed pipeline latency.
// - The palette module converts that index to RGB. The frame compositor muxes it over tank/background.

---
 rtl/tank_pkg.sv | 33 +++
 rtl/turret1_sprite_fetch_if.sv | 28 ++
 rtl/turret1_rom.sv | 17 +
 rtl/turret1_sprite_fetch.sv | 78 +++++++
 tb/tb_turret1_sprite_fetch.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// Shared constants, turret direction encoding and the turret sprite image for the
// turret sprite fetch pipeline.
package tank_pkg;

    localparam int SPRITE_DIM = 32;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int COORD_W    = 10;
    localparam int IDX_W      = 8;
    localparam int SPR_AW     = $clog2(SPRITE_DIM);
    localparam int ROM_AW     = 2 * SPR_AW;

    localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Sprite image as a closed-form pattern: column 0 is transparent, every
    // other texel encodes its own row/column so each address reads back distinctly.
    function automatic logic [IDX_W-1:0] turret_texel(input logic [ROM_AW-1:0] a);
        logic [SPR_AW-1:0] u;
        logic [SPR_AW-1:0] v;
        u = a[SPR_AW-1:0];
        v = a[ROM_AW-1:SPR_AW];
        if (u == '0) return TRANSP_IDX;
        return {v[2:0], u} + IDX_W'(v[4:3]);
    endfunction

endpackage

// File: rtl/turret1_sprite_fetch_if.sv
// Pixel stream and turret state bundle between the VGA timing/game logic
// (master) and the turret sprite fetch pipeline (slave).
interface turret1_sprite_fetch_if import tank_pkg::*; ();

    logic               pixel_en;
    logic               frame_start;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [COORD_W-1:0] turret_x;
    logic [COORD_W-1:0] turret_y;
    logic [1:0]         turret_dir;
    logic               turret_alive;
    logic [IDX_W-1:0]   pix_index;
    logic               pix_valid;

    modport master (
        output pixel_en, frame_start, DrawX, DrawY,
        output turret_x, turret_y, turret_dir, turret_alive,
        input  pix_index, pix_valid
    );

    modport slave (
        input  pixel_en, frame_start, DrawX, DrawY,
        input  turret_x, turret_y, turret_dir, turret_alive,
        output pix_index, pix_valid
    );

endinterface

// File: rtl/turret1_rom.sv
// 1024-entry turret index ROM, one-cycle synchronous read gated by the pixel strobe.
module turret1_rom import tank_pkg::*; (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr,
    output logic [IDX_W-1:0]  q
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            q <= '0;
        else if (en)
            q <= turret_texel(addr);
    end

endmodule

// File: rtl/turret1_sprite_fetch.sv
// Turret sprite fetch: per-pixel hit test and rotation against frame-latched turret
// state, ROM lookup, palette index out two pixel strobes later.
module turret1_sprite_fetch import tank_pkg::*; (
    input  logic                 Clk,
    input  logic                 Reset_n,
    turret1_sprite_fetch_if.slave bus
);

    localparam logic [SPR_AW-1:0] M = SPR_AW'(SPRITE_DIM - 1);

    logic [COORD_W-1:0] x_l, y_l;
    dir_t               dir_l;
    logic               alive_l;

    logic signed [COORD_W:0] dx, dy;
    logic                    hit_s0;
    logic [SPR_AW-1:0]       u, v;
    logic [ROM_AW-1:0]       rom_addr;
    logic [IDX_W-1:0]        rom_q, idx_d2;
    logic [2:1]              vld_pipe;

    // Turret state only changes at frame_start so the sprite never tears mid-frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_l     <= '0;
            y_l     <= '0;
            dir_l   <= DIR_UP;
            alive_l <= 1'b0;
        end else if (bus.frame_start) begin
            x_l     <= bus.turret_x;
            y_l     <= bus.turret_y;
            dir_l   <= dir_t'(bus.turret_dir);
            alive_l <= bus.turret_alive;
        end
    end

    // One extra bit keeps the subtraction signed, so pixels left/above the sprite
    // go negative instead of wrapping back into range.
    assign dx     = $signed({1'b0, bus.DrawX}) - $signed({1'b0, x_l});
    assign dy     = $signed({1'b0, bus.DrawY}) - $signed({1'b0, y_l});
    assign hit_s0 = (dx[COORD_W:SPR_AW] == '0) && (dy[COORD_W:SPR_AW] == '0);

    always_comb begin
        u = dx[SPR_AW-1:0];
        v = dy[SPR_AW-1:0];
        case (dir_l)
            DIR_UP:    begin u = dx[SPR_AW-1:0];     v = dy[SPR_AW-1:0];     end
            DIR_RIGHT: begin u = dy[SPR_AW-1:0];     v = M - dx[SPR_AW-1:0]; end
            DIR_DOWN:  begin u = M - dx[SPR_AW-1:0]; v = M - dy[SPR_AW-1:0]; end
            DIR_LEFT:  begin u = M - dy[SPR_AW-1:0]; v = dx[SPR_AW-1:0];     end
            default:   ;
        endcase
    end

    assign rom_addr = {v, u};

    turret1_rom u_rom (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (bus.pixel_en),
        .addr    (rom_addr),
        .q       (rom_q)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe <= '0;
            idx_d2   <= '0;
        end else if (bus.pixel_en) begin
            vld_pipe <= {vld_pipe[1], hit_s0 & alive_l};
            idx_d2   <= rom_q;
        end
    end

    assign bus.pix_valid = vld_pipe[2] && (idx_d2 != TRANSP_IDX);
    assign bus.pix_index = bus.pix_valid ? idx_d2 : '0;

endmodule

// File: tb/tb_turret1_sprite_fetch.sv
// Directed bench for turret1_sprite_fetch: vector table for position/rotation/clipping,
// plus sequences for reset, shadow latching and stalls.
module tb_turret1_sprite_fetch;
    import tank_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    turret1_sprite_fetch_if bus();

    turret1_sprite_fetch dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        string nm;
        int    tx, ty, dir, alive;
        int    px, py;
        int    exp_v, exp_i;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    task automatic check_out(input string nm, input int v, input int i);
        check({nm, ".valid"}, int'(bus.pix_valid), v);
        check({nm, ".index"}, int'(bus.pix_index), i);
    endtask

    task automatic frame(input int x, input int y, input int d, input int a);
        bus.turret_x     = COORD_W'(x);
        bus.turret_y     = COORD_W'(y);
        bus.turret_dir   = 2'(d);
        bus.turret_alive = a[0];
        bus.frame_start  = 1'b1;
        @(posedge Clk); #1;
        bus.frame_start  = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        bus.DrawX    = COORD_W'(x);
        bus.DrawY    = COORD_W'(y);
        bus.pixel_en = 1'b1;
        @(posedge Clk); #1;
        bus.pixel_en = 1'b0;
    endtask

    // Issue one pixel, push it through with a far-away filler pixel, then check.
    task automatic probe(input string nm, input int x, input int y, input int v, input int i);
        pix(x, y);
        pix(1023, 1023);
        check_out(nm, v, i);
    endtask

    initial begin
        // texel(v,u) = u==0 ? 0 : ({v[2:0],u} + v[4:3]) mod 256
        vt[0]  = '{"up_addr0_transp",  100, 50, 0, 1, 100,  50, 0,   0};
        vt[1]  = '{"up_addr31",        100, 50, 0, 1, 131,  50, 1,  31};
        vt[2]  = '{"up_right_edge",    100, 50, 0, 1, 132,  50, 0,   0};
        vt[3]  = '{"up_addr33",        100, 50, 0, 1, 101,  51, 1,  33};
        vt[4]  = '{"up_bottom_edge",   100, 50, 0, 1, 101,  82, 0,   0};
        vt[5]  = '{"up_left_of",       100, 50, 0, 1,  99,  51, 0,   0};
        vt[6]  = '{"rot_right_901",      0,  0, 1, 1,   3,   5, 1, 136};
        vt[7]  = '{"rot_down_860",       0,  0, 2, 1,   3,   5, 1,  95};
        vt[8]  = '{"rot_left_122",       0,  0, 3, 1,   3,   5, 1, 122};
        vt[9]  = '{"clip_corner",      620,470, 0, 1, 639, 479, 1,  52};
        vt[10] = '{"clip_inner",       620,470, 0, 1, 621, 471, 1,  33};
        vt[11] = '{"clip_no_alias_x0", 620,470, 0, 1,   0, 470, 0,   0};
        vt[12] = '{"clip_no_alias_x11",620,470, 0, 1,  11, 475, 0,   0};
        vt[13] = '{"offscreen_x640",   640,  0, 0, 1, 639,   0, 0,   0};
        vt[14] = '{"offscreen_x1000", 1000,  0, 0, 1,   5,   3, 0,   0};
        vt[15] = '{"dead_turret",      100, 50, 0, 0, 131,  50, 0,   0};

        bus.pixel_en = 1'b0; bus.frame_start = 1'b0;
        bus.DrawX = '0; bus.DrawY = '0;
        bus.turret_x = '0; bus.turret_y = '0; bus.turret_dir = '0; bus.turret_alive = 1'b0;

        // Reset state, then nothing drawn before the first frame_start (latched x=y=0
        // would otherwise hit at (31,0)).
        repeat (3) @(posedge Clk); #1;
        check_out("reset_state", 0, 0);
        Reset_n = 1'b1;
        probe("post_reset_no_frame", 31, 0, 0, 0);
        frame(0, 0, 0, 1);
        probe("first_frame_visible", 31, 0, 1, 31);

        // Reset mid-stream clears outputs immediately and kills the latched state.
        pix(31, 0);
        pix(31, 0);
        check_out("pre_reset_live", 1, 31);
        Reset_n = 1'b0;
        #2;
        check_out("async_reset", 0, 0);
        pix(31, 0);
        #3 Reset_n = 1'b1;
        probe("after_midframe_reset", 31, 0, 0, 0);

        foreach (vt[k]) begin
            frame(vt[k].tx, vt[k].ty, vt[k].dir, vt[k].alive);
            probe(vt[k].nm, vt[k].px, vt[k].py, vt[k].exp_v, vt[k].exp_i);
        end

        // Live turret_x changes are ignored until frame_start.
        frame(100, 50, 0, 1);
        bus.turret_x = 10'd200;
        probe("latch_old_pos_hit", 131, 50, 1, 31);
        probe("latch_new_pos_miss", 231, 50, 0, 0);
        frame(200, 50, 0, 1);
        probe("latch_shifted_hit", 231, 50, 1, 31);
        probe("latch_old_pos_miss", 131, 50, 0, 0);

        // frame_start and pixel_en together: that pixel sees the old shadow state.
        bus.turret_x    = 10'd100;
        bus.frame_start = 1'b1;
        pix(231, 50);
        bus.frame_start = 1'b0;
        pix(1023, 1023);
        check_out("same_cycle_old_state", 1, 31);
        probe("same_cycle_new_state", 131, 50, 1, 31);

        // Stall: output and the pixel waiting in S1 both hold across pixel_en=0.
        pix(131, 50);
        pix(101, 51);
        for (int c = 0; c < 3; c++) begin
            bus.DrawX = COORD_W'(100 + c);
            bus.DrawY = 10'd60;
            @(posedge Clk); #1;
            check_out($sformatf("stall_frozen%0d", c), 1, 31);
        end
        pix(1023, 1023);
        check_out("stall_resume", 1, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
